// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch / load-store memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  localparam int unsigned MEM_LAT_MIN    = 1;
  localparam int unsigned MEM_LAT_MAX    = 4;
  localparam int unsigned STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arbiter_resp_tag_pipe.sv
// Owner-tag delay line: tracks who issued each memory read until its data returns.
module resp_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic   clk,
  input  logic   clear,
  input  owner_e tag_in,
  output owner_e tag_out
);

  owner_e stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage[i] <= OWN_NONE;
      end
    end else begin
      stage[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch and load/store, LS priority with a
// starvation bound for fetch, and fixed-latency response routing.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [3:0]        ls_be,
  input  logic [31:0]       ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT out of range");
  end

  logic [CNT_W-1:0] starve_cnt;
  logic             force_if;
  owner_e           tag_in;
  owner_e           tag_out;

  // Fetch wins a contended cycle only once it has lost STARVE_MAX in a row.
  always_comb begin
    force_if = (starve_cnt == CNT_W'(STARVE_MAX));
    if_gnt   = 1'b0;
    ls_gnt   = 1'b0;
    if (!reset) begin
      if (if_req && (!ls_req || force_if)) begin
        if_gnt = 1'b1;
      end else if (ls_req) begin
        ls_gnt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || if_gnt || !if_req) begin
      starve_cnt <= '0;
    end else if (ls_gnt && !force_if) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_comb begin
    mem_en    = if_gnt | ls_gnt;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    tag_in    = OWN_NONE;
    if (if_gnt) begin
      mem_addr = if_addr;
      tag_in   = OWN_IF;
    end else if (ls_gnt) begin
      mem_addr  = ls_addr[ADDR_W+1:2];
      mem_we    = ls_we;
      mem_be    = ls_be;
      mem_wdata = ls_wdata;
      tag_in    = ls_we ? OWN_NONE : OWN_LS;
    end
  end

  resp_tag_pipe #(
    .DEPTH(MEM_LAT)
  ) u_tag_pipe (
    .clk    (clk),
    .clear  (reset),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  // Gating with reset keeps a tag already at the output from escaping during reset.
  assign if_rvalid = !reset && (tag_out == OWN_IF);
  assign ls_rvalid = !reset && (tag_out == OWN_LS);
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: three arbiters (MEM_LAT 1..3) share stimulus and are
// compared against a queue-of-responses reference model.
module tb_mem_arbiter;

  localparam int NL = 3;
  localparam int SM = 4;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [9:0]  if_addr;
  logic        ls_req;
  logic        ls_we;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;

  logic        if_gnt_w    [NL];
  logic        if_rvalid_w [NL];
  logic [31:0] if_rdata_w  [NL];
  logic        ls_gnt_w    [NL];
  logic        ls_rvalid_w [NL];
  logic [31:0] ls_rdata_w  [NL];
  logic        mem_en_w    [NL];
  logic        mem_we_w    [NL];
  logic [3:0]  mem_be_w    [NL];
  logic [9:0]  mem_addr_w  [NL];
  logic [31:0] mem_wdata_w [NL];

  function automatic logic [31:0] init_word(input int i);
    return (i == 16) ? 32'hDEADBEEF : (i * 32'h9E3779B1) + 32'h0000_1357;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int L = g + 1;
    logic [31:0] mem  [1024];
    logic [31:0] pipe [L];

    mem_arbiter #(
      .ADDR_W    (10),
      .MEM_LAT   (L),
      .STARVE_MAX(SM)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_gnt   (if_gnt_w[g]),
      .if_rvalid(if_rvalid_w[g]),
      .if_rdata (if_rdata_w[g]),
      .ls_req   (ls_req),
      .ls_we    (ls_we),
      .ls_be    (ls_be),
      .ls_addr  (ls_addr),
      .ls_wdata (ls_wdata),
      .ls_gnt   (ls_gnt_w[g]),
      .ls_rvalid(ls_rvalid_w[g]),
      .ls_rdata (ls_rdata_w[g]),
      .mem_en   (mem_en_w[g]),
      .mem_we   (mem_we_w[g]),
      .mem_be   (mem_be_w[g]),
      .mem_addr (mem_addr_w[g]),
      .mem_wdata(mem_wdata_w[g]),
      .mem_rdata(pipe[L-1])
    );

    initial begin
      for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
      for (int k = 0; k < L; k++) pipe[k] = '0;
    end

    always @(posedge clk) begin
      if (mem_en_w[g]) begin
        if (mem_we_w[g]) begin
          for (int b = 0; b < 4; b++)
            if (mem_be_w[g][b]) mem[mem_addr_w[g]][8*b +: 8] <= mem_wdata_w[g][8*b +: 8];
        end else begin
          pipe[0] <= mem[mem_addr_w[g]];
        end
      end
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
  end

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [9:0]  if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [1:0]  exp_gnt;   // {if, ls}
    logic [9:0]  exp_addr;
  } vec_t;

  // Reference model state
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          lost    = 0;
  logic [31:0] ref_mem [1024];
  int          p_own   [NL][16];   // 0 none, 1 fetch, 2 load/store
  logic [31:0] p_dat   [NL][16];
  logic        m_if, m_ls;

  // Samples from the most recent cycle
  logic [1:0]  s_gnt;
  logic [9:0]  s_addr;
  logic        s_if_rv [NL];
  logic        s_ls_rv [NL];
  logic [31:0] s_if_rd [NL];
  logic [31:0] s_ls_rd [NL];

  task automatic chk(input string name, input int ln, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d cyc%0d: got %h expected %h", name, ln, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic ir, input logic [9:0] ia,
                              input logic lr, input logic lw, input logic [3:0] lb,
                              input logic [31:0] la, input logic [31:0] lwd,
                              input logic [1:0] eg, input logic [9:0] ea);
    vec_t v;
    v.rst = rst; v.if_req = ir; v.if_addr = ia; v.ls_req = lr; v.ls_we = lw;
    v.ls_be = lb; v.ls_addr = la; v.ls_wdata = lwd; v.exp_gnt = eg; v.exp_addr = ea;
    return v;
  endfunction

  // Drives one cycle, checks every lane against the model mid-cycle, advances the model.
  task automatic cycle(input vec_t v);
    logic       eif, els, erd;
    logic [9:0] ea;
    int         slot;
    reset = v.rst; if_req = v.if_req; if_addr = v.if_addr; ls_req = v.ls_req;
    ls_we = v.ls_we; ls_be = v.ls_be; ls_addr = v.ls_addr; ls_wdata = v.ls_wdata;
    @(negedge clk);
    eif  = !v.rst && v.if_req && (!v.ls_req || lost == SM);
    els  = !v.rst && v.ls_req && !eif;
    erd  = eif || (els && !v.ls_we);
    ea   = eif ? v.if_addr : (els ? v.ls_addr[11:2] : 10'd0);
    slot = cyc % 16;
    for (int g = 0; g < NL; g++) begin
      chk("if_gnt", g, if_gnt_w[g], eif);
      chk("ls_gnt", g, ls_gnt_w[g], els);
      chk("mem_en", g, mem_en_w[g], eif || els);
      chk("mem_we", g, mem_we_w[g], els && v.ls_we);
      chk("mem_be", g, mem_be_w[g], els ? v.ls_be : 4'h0);
      if (eif || els) chk("mem_addr", g, mem_addr_w[g], ea);
      if (els && v.ls_we) chk("mem_wdata", g, mem_wdata_w[g], v.ls_wdata);
      chk("if_rvalid", g, if_rvalid_w[g], !v.rst && p_own[g][slot] == 1);
      chk("ls_rvalid", g, ls_rvalid_w[g], !v.rst && p_own[g][slot] == 2);
      if (!v.rst && p_own[g][slot] == 1) chk("if_rdata", g, if_rdata_w[g], p_dat[g][slot]);
      if (!v.rst && p_own[g][slot] == 2) chk("ls_rdata", g, ls_rdata_w[g], p_dat[g][slot]);
      s_if_rv[g] = if_rvalid_w[g]; s_ls_rv[g] = ls_rvalid_w[g];
      s_if_rd[g] = if_rdata_w[g];  s_ls_rd[g] = ls_rdata_w[g];
      p_own[g][slot] = 0;
      if (v.rst) begin
        for (int k = 0; k < 16; k++) p_own[g][k] = 0;
      end else if (erd) begin
        p_own[g][(cyc + g + 1) % 16] = eif ? 1 : 2;
        p_dat[g][(cyc + g + 1) % 16] = ref_mem[ea];
      end
    end
    s_gnt  = {if_gnt_w[0], ls_gnt_w[0]};
    s_addr = mem_addr_w[0];
    if (els && v.ls_we)
      for (int b = 0; b < 4; b++)
        if (v.ls_be[b]) ref_mem[ea][8*b +: 8] = v.ls_wdata[8*b +: 8];
    if (v.rst || !v.if_req || eif) lost = 0;
    else if (lost < SM) lost++;
    m_if = eif; m_ls = els;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t idle();
    return mk(0, 0, 10'h0, 0, 0, 4'h0, 32'h0, 32'h0, 2'b00, 10'h0);
  endfunction

  vec_t tbl[$];
  vec_t cur;
  logic pend_if, pend_ls;

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    for (int g = 0; g < NL; g++)
      for (int k = 0; k < 16; k++) begin p_own[g][k] = 0; p_dat[g][k] = '0; end
    reset = 1'b1; if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0;
    ls_be = '0; ls_addr = '0; ls_wdata = '0;
    @(posedge clk); #1;

    // Reset with both requesters active: nothing may be granted.
    tbl.push_back(mk(1, 1, 10'h010, 1, 0, 4'h0, 32'h40, 32'h0, 2'b00, 10'h0));
    // Fetch only
    tbl.push_back(mk(0, 1, 10'h010, 0, 0, 4'h0, 32'h0, 32'h0, 2'b10, 10'h010));
    tbl.push_back(idle());
    // Continuous contention: every fifth cycle goes to fetch
    for (int i = 0; i < 12; i++)
      tbl.push_back(mk(0, 1, 10'h020, 1, 0, 4'h0, 32'h80, 32'h0,
                       (i % 5 == 4) ? 2'b10 : 2'b01, 10'h020));
    tbl.push_back(idle());
    // Starvation credit cleared by a one-cycle fetch drop
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 10'h005, 1, 0, 4'h0, 32'h1C, 32'h0, 2'b01, 10'h007));
    tbl.push_back(mk(0, 0, 10'h005, 1, 0, 4'h0, 32'h1C, 32'h0, 2'b01, 10'h007));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1, 10'h005, 1, 0, 4'h0, 32'h1C, 32'h0, 2'b01, 10'h007));
    tbl.push_back(mk(0, 1, 10'h005, 1, 0, 4'h0, 32'h1C, 32'h0, 2'b10, 10'h005));
    tbl.push_back(idle());
    tbl.push_back(idle());
    // Read in flight killed by reset (aliased high address bits)
    tbl.push_back(mk(0, 0, 10'h0, 1, 0, 4'h0, 32'hF000_0086, 32'h0, 2'b01, 10'h021));
    tbl.push_back(mk(1, 1, 10'h3, 1, 1, 4'hF, 32'h84, 32'h5555_5555, 2'b00, 10'h0));
    for (int i = 0; i < 4; i++) tbl.push_back(idle());

    foreach (tbl[i]) begin
      cycle(tbl[i]);
      chk("tbl_gnt", 0, s_gnt, tbl[i].exp_gnt);
      if (tbl[i].exp_gnt != 2'b00) chk("tbl_addr", 0, s_addr, tbl[i].exp_addr);
    end

    // Store then load to the same word
    cycle(mk(0, 0, 10'h0, 1, 1, 4'b0011, 32'h40, 32'h1234_ABCD, 2'b01, 10'h010));
    chk("st_addr", 0, s_addr, 10'h010);
    cycle(mk(0, 0, 10'h0, 1, 0, 4'h0, 32'h40, 32'h0, 2'b01, 10'h010));
    chk("st_no_rvalid", 0, s_ls_rv[0], 1'b0);
    chk("ld_addr", 0, s_addr, 10'h010);
    cycle(idle());
    chk("ld_rvalid", 0, s_ls_rv[0], 1'b1);
    chk("ld_low16", 0, {16'h0, s_ls_rd[0][15:0]}, 32'h0000_ABCD);
    for (int i = 0; i < 3; i++) cycle(idle());

    // Pipelined IF, LS, IF reads on the MEM_LAT=3 lane
    cycle(mk(0, 1, 10'h001, 0, 0, 4'h0, 32'h0, 32'h0, 2'b10, 10'h001));
    cycle(mk(0, 0, 10'h000, 1, 0, 4'h0, 32'h8, 32'h0, 2'b01, 10'h002));
    cycle(mk(0, 1, 10'h003, 0, 0, 4'h0, 32'h0, 32'h0, 2'b10, 10'h003));
    cycle(idle());
    chk("pipe_c3_if", 2, {s_if_rv[2], s_ls_rv[2]}, 2'b10);
    chk("pipe_c3_dat", 2, s_if_rd[2], init_word(1));
    cycle(idle());
    chk("pipe_c4_ls", 2, {s_if_rv[2], s_ls_rv[2]}, 2'b01);
    chk("pipe_c4_dat", 2, s_ls_rd[2], init_word(2));
    cycle(idle());
    chk("pipe_c5_if", 2, {s_if_rv[2], s_ls_rv[2]}, 2'b10);
    chk("pipe_c5_dat", 2, s_if_rd[2], init_word(3));

    // Randomized traffic; requesters hold their request until granted
    cur = idle();
    pend_if = 0; pend_ls = 0;
    for (int n = 0; n < 800; n++) begin
      if (!pend_if) begin
        cur.if_req  = ($urandom_range(0, 3) != 0);
        cur.if_addr = 10'($urandom_range(0, 31));
      end
      if (!pend_ls) begin
        cur.ls_req   = ($urandom_range(0, 2) != 0);
        cur.ls_we    = 1'($urandom_range(0, 1));
        cur.ls_be    = 4'($urandom);
        cur.ls_addr  = $urandom & 32'hFFFF_F07F;
        cur.ls_wdata = $urandom;
      end
      cur.rst = ($urandom_range(0, 63) == 0);
      cycle(cur);
      pend_if = cur.if_req && !m_if;
      pend_ls = cur.ls_req && !m_ls;
    end
    for (int i = 0; i < 4; i++) cycle(idle());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
